// File: rtl/ram_param_pkg.sv
// Shared definitions for ram_param: clear-FSM states, legal read-latency range
// and the even byte-parity helper.
package ram_param_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, one write per cycle,
// and holds busy high until the last address has been zeroed.
module ram_clear_seq
  import ram_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_address
);

  state_t              state;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // The extra top bit flags "one past the last address" instead of wrapping to 0.
  assign cnt_nxt = cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt_nxt;
          if (cnt_nxt[ADDR_WIDTH]) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Suppressed during rst so reset itself never writes the array.
  assign clr_we      = (state == CLEAR) & ~rst;
  assign clr_address = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_param.sv
// Byte-enabled single-clock RAM with self-clearing after reset and 1- or 2-cycle
// read latency; optional per-byte even parity when RAM_PARITY_EN is defined.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    parity_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_address;

  ram_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .clr_we     (clr_we),
    .clr_address(clr_address)
  );

  logic user_ok;
  logic wr_ok;
  logic rd_ok;
  logic hit;

  assign user_ok = ~busy & ~rst;
  assign wr_ok   = user_ok & we;
  assign rd_ok   = user_ok & rd_en;
  assign hit     = wr_ok & (address == rd_address);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // Write-first: bytes being written this cycle bypass the array on a same-address read.
  always_comb begin
    rd_word = mem[rd_address];
    for (int i = 0; i < NB; i++) begin
      if (hit && be[i]) rd_word[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_address] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[address][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] mem_par [DEPTH];
  logic [NB-1:0] in_par;
  logic [NB-1:0] rd_par;
  logic          rd_err;
  logic          p_err;

  always_comb begin
    for (int i = 0; i < NB; i++) in_par[i] = byte_parity(data_in[8*i +: 8]);
  end

  always_comb begin
    rd_par = mem_par[rd_address];
    for (int i = 0; i < NB; i++) begin
      if (hit && be[i]) rd_par[i] = in_par[i];
    end
  end

  always_comb begin
    rd_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (byte_parity(rd_word[8*i +: 8]) != rd_par[i]) rd_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_par[clr_address] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_par[address][i] <= in_par[i];
      end
    end
  end
`endif

  // p_* is the stage feeding the output register; RD_LATENCY > 1 inserts one more flop.
  logic                  p_vld;
  logic [DATA_WIDTH-1:0] p_dat;

  generate
    if (RD_LATENCY >= RD_LAT_MAX) begin : g_lat2
      logic                  s1_vld;
      logic [DATA_WIDTH-1:0] s1_dat;

      always_ff @(posedge clk) begin
        if (rst) s1_vld <= 1'b0;
        else     s1_vld <= rd_ok;
        if (rd_ok) s1_dat <= rd_word;
      end

      assign p_vld = s1_vld;
      assign p_dat = s1_dat;
`ifdef RAM_PARITY_EN
      logic s1_err;
      always_ff @(posedge clk) begin
        if (rd_ok) s1_err <= rd_err;
      end
      assign p_err = s1_err;
`endif
    end else begin : g_lat1
      assign p_vld = rd_ok;
      assign p_dat = rd_word;
`ifdef RAM_PARITY_EN
      assign p_err = rd_err;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= p_vld;
      if (p_vld) data_out <= p_dat;
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= p_vld & p_err;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 16, address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter RD_LATENCY, default 1, read latency in cycles; legal values SHALL be 1 or 2.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 we  in  1  write enable.
REQ-007 be  in  DATA_WIDTH/8  byte enables; bit i SHALL qualify data_in byte i.
REQ-008 address  in  ADDR_WIDTH  write address.
REQ-009 data_in  in  DATA_WIDTH  write data.
REQ-010 rd_en  in  1  read request.
REQ-011 rd_address  in  ADDR_WIDTH  read address.
REQ-012 data_out  out  DATA_WIDTH  read data, valid when rd_valid=1.
REQ-013 rd_valid  out  1  read data qualifier.
REQ-014 busy  out  1  high while reset or clear sequence is active.
REQ-015 parity_err  out  1  parity mismatch flag, aligned with rd_valid.

Function
REQ-016 FSM states SHALL be CLEAR and READY; rst SHALL force CLEAR with clear counter 0.
REQ-017 In CLEAR, the block SHALL write all-zero data (and correct parity) to counter address each cycle, then increment the counter.
REQ-018 After writing address 2**ADDR_WIDTH-1, the FSM SHALL go to READY; clear SHALL take exactly 2**ADDR_WIDTH cycles after rst deasserts.
REQ-019 busy SHALL be 1 in CLEAR and while rst=1, and 0 in READY.
REQ-020 In CLEAR, we and rd_en SHALL be ignored: no user write, no rd_valid.
REQ-021 In READY, we=1 SHALL update byte i of mem[address] only when be[i]=1; we=1 with be=0 SHALL leave memory unchanged.
REQ-022 In READY, rd_en=1 SHALL produce rd_valid=1 and data_out=mem[rd_address] exactly RD_LATENCY cycles later; back-to-back reads SHALL be accepted every cycle.
REQ-023 Same-cycle read and write to the same address SHALL return the merged new word (write-first, per enabled byte).
REQ-024 When rd_valid=0, data_out SHALL hold its last value.
REQ-025 Address arithmetic of the clear counter SHALL be ADDR_WIDTH+1 bits wide so termination is detected without wrap to 0.

Reset
REQ-026 On rst: data_out=0, rd_valid=0, parity_err=0, busy=1, read pipeline flushed, state=CLEAR, counter=0.
REQ-027 rst asserted mid-clear or mid-read SHALL restart the clear from address 0 and drop any in-flight read.
REQ-028 Memory contents SHALL NOT be touched by rst directly; they SHALL be zeroed only by the clear sequence.

Configuration
REQ-029 Macro RAM_PARITY_EN defined: one even-parity bit SHALL be stored per byte on write and checked on read; parity_err=1 with rd_valid when any byte mismatches.
REQ-030 Macro RAM_PARITY_EN undefined: no parity storage; parity_err SHALL be tied 0.

Structure
REQ-031 Package ram_param_pkg SHALL hold the state enum (CLEAR, READY), the RD_LATENCY legal-range constants and the byte-parity function.
REQ-032 The clear FSM and counter SHALL be a sub-module ram_clear_seq (outputs: busy, clr_we, clr_address).

Verification
REQ-033 ADDR_WIDTH=4: rst 2 cycles then release -> busy=1 for exactly 16 cycles; read of every address 0..15 -> 00.
REQ-034 Defaults, after clear: write address 0001 data AB be=1; next cycle read 0001 -> rd_valid and data_out=AB after RD_LATENCY cycles; write 0002 CD, read 0002 -> CD.
REQ-035 DATA_WIDTH=32: write 11223344 be=F to 0005, then AABBCCDD be=0101b -> read returns 11BB33DD.
REQ-036 Same-cycle write 5A to 0003 and read 0003 -> data_out=5A; RD_LATENCY=2 -> rd_valid pulse exactly 2 cycles after rd_en, reads on 3 consecutive cycles -> 3 consecutive rd_valid.
REQ-037 rst asserted at clear counter 8 (ADDR_WIDTH=4) -> busy stays 1 for 16 full cycles after release; we/rd_en during busy -> no write, rd_valid=0.
REQ-038 RAM_PARITY_EN defined: force-flip one stored data bit at 0007 via hierarchical write, read 0007 -> parity_err=1 with rd_valid; clean address -> parity_err=0.
